serial_add_ctrl: RTL
====================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to add the presented operands; sampled only in IDLE.
REQ-005 a  input  WIDTH  first operand, captured on the accepting edge.
REQ-006 b  input  WIDTH  second operand, captured on the accepting edge.
REQ-007 ci  input  1  carry-in, captured on the accepting edge.
REQ-008 busy  output  1  high while the bit-serial addition is in progress.
REQ-009 done  output  1  one-cycle pulse marking a fresh result.
REQ-010 s  output  WIDTH  result sum, held until the next completed operation.
REQ-011 co  output  1  result carry-out, held with s.

Function
REQ-012 The block SHALL sequence a single 1-bit full-adder cell (s = a^b^ci, co = majority) over WIDTH cycles, LSB first.
REQ-013 FSM states SHALL be IDLE, RUN, DONE; encoding free; unreachable encodings SHALL return to IDLE.
REQ-014 IDLE: start=1 at an edge SHALL capture a, b into operand shift registers, ci into the carry flop, clear the bit counter, enter RUN.
REQ-015 IDLE with start=0 SHALL hold all state.
REQ-016 RUN: each edge SHALL apply the full-adder to operand LSBs and carry flop, shift the sum bit in at the MSB of an internal sum shift register, shift both operands right by one, update the carry flop with co, increment the counter.
REQ-017 On the WIDTH-th RUN edge the block SHALL load s from the completed sum shift register, co from the final carry, and enter DONE.
REQ-018 DONE SHALL last exactly one cycle and SHALL unconditionally return to IDLE.
REQ-019 Latency: start accepted at edge 0 -> s/co updated and done=1 after edge WIDTH; done=0 after edge WIDTH+1.
REQ-020 busy SHALL be 1 exactly in RUN (WIDTH cycles), 0 in IDLE and DONE.
REQ-021 done SHALL be 1 exactly in DONE.
REQ-022 start while in RUN or DONE SHALL be ignored (not queued); earliest next acceptance is the first edge in IDLE.
REQ-023 Changes on a, b, ci after acceptance SHALL NOT affect the running operation.
REQ-024 s and co SHALL change only at the REQ-017 edge or reset; intermediate bits SHALL NOT be visible on s.
REQ-025 Result SHALL equal (a + b + ci) mod 2^WIDTH on s and bit WIDTH of that sum on co.
REQ-026 Counter SHALL be ceil(log2(WIDTH+1)) bits; no wrap-around occurs in legal operation.

Reset
REQ-027 rst=1 SHALL immediately, without a clock edge, force IDLE, busy=0, done=0, s=0, co=0, and clear operand, sum, carry and counter registers.
REQ-028 rst asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-029 After rst deasserts, the first edge with start=1 SHALL be accepted normally.

Verification
REQ-030 WIDTH=8, a=8'h3C, b=8'h05, ci=0, start pulse -> busy high 8 cycles, done after edge 8, s=8'h41, co=0.
REQ-031 a=8'hFF, b=8'h01, ci=0 -> s=8'h00, co=1; a=8'hFF, b=8'hFF, ci=1 -> s=8'hFF, co=1.
REQ-032 start held high continuously -> operations back-to-back with one IDLE cycle between DONE and next RUN; every start during RUN/DONE ignored.
REQ-033 a/b toggled every cycle during RUN -> result matches values at acceptance edge.
REQ-034 rst pulsed asynchronously at RUN cycle 4 -> outputs zero immediately, no done; subsequent 8'h10+8'h20 -> s=8'h30.
REQ-035 Random a, b, ci, 1000 operations vs reference model; also WIDTH=2 corner: 2'b11+2'b11+1 -> s=2'b11, co=1.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell sequenced LSB-first over WIDTH cycles.
// Operands are captured on start, and the sum/carry are published with a one-cycle done pulse.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   a_sr, a_sr_next;
    logic [WIDTH-1:0]   b_sr, b_sr_next;
    logic [WIDTH-1:0]   sum_sr, sum_sr_next;
    logic               carry, carry_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [WIDTH-1:0]   s_next;
    logic               co_next;
    logic               busy_next;
    logic               done_next;

    logic               fa_sum;
    logic               fa_co;

    // The single full-adder cell shared by every bit position
    assign fa_sum = a_sr[0] ^ b_sr[0] ^ carry;
    assign fa_co  = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            s      <= '0;
            co     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_next;
            a_sr   <= a_sr_next;
            b_sr   <= b_sr_next;
            sum_sr <= sum_sr_next;
            carry  <= carry_next;
            cnt    <= cnt_next;
            s      <= s_next;
            co     <= co_next;
            busy   <= busy_next;
            done   <= done_next;
        end
    end

    // busy/done are registered from the state being entered, so they track the state exactly
    always_comb begin
        state_next  = state;
        a_sr_next   = a_sr;
        b_sr_next   = b_sr;
        sum_sr_next = sum_sr;
        carry_next  = carry;
        cnt_next    = cnt;
        s_next      = s;
        co_next     = co;
        busy_next   = 1'b0;
        done_next   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    a_sr_next   = a;
                    b_sr_next   = b;
                    sum_sr_next = '0;
                    carry_next  = ci;
                    cnt_next    = '0;
                    state_next  = RUN;
                    busy_next   = 1'b1;
                end
            end
            RUN: begin
                a_sr_next   = {1'b0, a_sr[WIDTH-1:1]};
                b_sr_next   = {1'b0, b_sr[WIDTH-1:1]};
                sum_sr_next = {fa_sum, sum_sr[WIDTH-1:1]};
                carry_next  = fa_co;
                cnt_next    = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    s_next     = {fa_sum, sum_sr[WIDTH-1:1]};
                    co_next    = fa_co;
                    state_next = DONE;
                    done_next  = 1'b1;
                end else begin
                    busy_next  = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
